// File: rtl/wb_bypass_buffer.sv
// Write-back bypass: forwards live WB data and a DEPTH-deep history of retired writes to every read port.
// Latency: forwarding is combinational (zero cycles); history and hit counter update on each rising edge.
// Backpressure: none; the history shifts every cycle because the register file commits independently.
module wb_bypass_buffer #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16,
  parameter int SRC_W    = $clog2(DEPTH + 2)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_READ*DATA_W-1:0]   rd_data_rf,
  output logic [NUM_READ*DATA_W-1:0]   rd_data_out,
  output logic [NUM_READ-1:0]          fwd_hit,
  output logic [NUM_READ*SRC_W-1:0]    fwd_src,
  input  logic                         clr_cnt,
  output logic [CNT_W-1:0]             fwd_cnt
);

  localparam int HIT_W = $clog2(NUM_READ + 1);
  localparam int SUM_W = CNT_W + HIT_W;

  // History of retired writes; index 0 is the youngest.
  logic              hist_vld  [DEPTH];
  logic [ADDR_W-1:0] hist_addr [DEPTH];
  logic [DATA_W-1:0] hist_data [DEPTH];

  // A write to the hardwired zero register is retired as an invalid entry.
  logic wb_store_vld;
  assign wb_store_vld = wb_we & ~((ZERO_REG != 0) & (wb_addr == '0));

  // Live WB only participates once reset is released.
  logic live_en;
  assign live_en = rst_n & wb_we;

  // Shift the history every cycle; reset drops everything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_vld[i]  <= 1'b0;
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else begin
      hist_vld[0]  <= wb_store_vld;
      hist_addr[0] <= wb_addr;
      hist_data[0] <= wb_data;
      for (int i = 1; i < DEPTH; i++) begin
        hist_vld[i]  <= hist_vld[i-1];
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              rd_ok;
    logic [DATA_W-1:0] sel_data;
    logic [SRC_W-1:0]  sel_src;
    logic              sel_hit;

    assign ra    = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_ok = ~((ZERO_REG != 0) & (ra == '0));

    // Fixed-priority select: live WB over youngest history entry over RF.
    // History is scanned oldest-first so a younger match overrides an older one.
    always_comb begin
      sel_data = rd_data_rf[p*DATA_W +: DATA_W];
      sel_src  = '0;
      sel_hit  = 1'b0;
      if (rd_ok) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (hist_vld[i] && (hist_addr[i] == ra)) begin
            sel_data = hist_data[i];
            sel_src  = SRC_W'(i + 2);
            sel_hit  = 1'b1;
          end
        end
        if (live_en && (wb_addr == ra)) begin
          sel_data = wb_data;
          sel_src  = SRC_W'(1);
          sel_hit  = 1'b1;
        end
      end
    end

    assign rd_data_out[p*DATA_W +: DATA_W] = sel_data;
    assign fwd_src[p*SRC_W +: SRC_W]       = sel_src;
    assign fwd_hit[p]                      = sel_hit;
  end

  logic [HIT_W-1:0] hit_sum;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Count this cycle's forwarding ports and saturate the running total.
  always_comb begin
    hit_sum = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      hit_sum = hit_sum + HIT_W'(fwd_hit[p]);
    end
    cnt_sum = SUM_W'(fwd_cnt) + SUM_W'(hit_sum);
    if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
      cnt_next = {CNT_W{1'b1}};
    end else begin
      cnt_next = cnt_sum[CNT_W-1:0];
    end
  end

  // Hit counter; a clear wins over the hits of the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
    end else if (clr_cnt) begin
      fwd_cnt <= '0;
    end else begin
      fwd_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_bypass_buffer.sv
// Bench for wb_bypass_buffer: directed scenarios with literal expectations, then randomized traffic.
// Reference: a log of every retired write indexed by cycle; a read takes the youngest write of its age window.
// Two instances share the inputs: the default one and one with a 2-bit counter to reach saturation.
module tb_wb_bypass_buffer;
  localparam int DW = 24;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int DP = 2;
  localparam int SW = 2;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, wb_we, clr_cnt;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_rf, rd_data_out, rd_data_out2;
  logic [NR-1:0]    fwd_hit, fwd_hit2;
  logic [NR*SW-1:0] fwd_src, fwd_src2;
  logic [15:0]      fwd_cnt;
  logic [1:0]       fwd_cnt2;

  wb_bypass_buffer #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .DEPTH(DP), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rd_data_rf(rd_data_rf), .rd_data_out(rd_data_out),
    .fwd_hit(fwd_hit), .fwd_src(fwd_src), .clr_cnt(clr_cnt), .fwd_cnt(fwd_cnt));

  wb_bypass_buffer #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .DEPTH(DP), .ZERO_REG(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rd_data_rf(rd_data_rf), .rd_data_out(rd_data_out2),
    .fwd_hit(fwd_hit2), .fwd_src(fwd_src2), .clr_cnt(clr_cnt), .fwd_cnt(fwd_cnt2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle write log and counter totals.
  logic          lg_vld  [LOGN];
  logic [AW-1:0] lg_addr [LOGN];
  logic [DW-1:0] lg_data [LOGN];
  int cyc = 0;
  int m_cnt = 0;
  int m_cnt2 = 0;

  // Expected data/source for port p: live write, else the youngest write of the last DP cycles, else RF.
  function automatic void model_port(input int p, output logic [DW-1:0] d, output logic [SW-1:0] s);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    d = rd_data_rf[p*DW +: DW];
    s = '0;
    if (!rst_n || a == '0) return;
    if (wb_we && wb_addr == a) begin
      d = wb_data;
      s = SW'(1);
      return;
    end
    for (int age = 1; age <= DP; age++) begin
      int idx;
      idx = cyc - age;
      if (idx >= 0 && lg_vld[idx] && lg_addr[idx] == a) begin
        d = lg_data[idx];
        s = SW'(age + 1);
        return;
      end
    end
  endfunction

  // Model update at each rising edge, using the inputs of the cycle that is ending.
  always @(posedge clk) begin
    int hits;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    hits = 0;
    for (int p = 0; p < NR; p++) begin
      model_port(p, d, s);
      if (s != '0) hits++;
    end
    if (!rst_n) begin
      m_cnt = 0;
      m_cnt2 = 0;
      lg_vld[cyc] = 1'b0;
      for (int k = 1; k <= DP; k++) if (cyc - k >= 0) lg_vld[cyc-k] = 1'b0;
    end else begin
      if (clr_cnt) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else begin
        m_cnt  = (m_cnt + hits > 65535) ? 65535 : m_cnt + hits;
        m_cnt2 = (m_cnt2 + hits > 3) ? 3 : m_cnt2 + hits;
      end
      lg_vld[cyc]  = wb_we && (wb_addr != '0);
      lg_addr[cyc] = wb_addr;
      lg_data[cyc] = wb_data;
    end
    if (cyc < LOGN - 1) cyc++;
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    for (int p = 0; p < NR; p++) begin
      model_port(p, d, s);
      chk($sformatf("data p%0d", p), 32'(rd_data_out[p*DW +: DW]), 32'(d));
      chk($sformatf("src p%0d", p), 32'(fwd_src[p*SW +: SW]), 32'(s));
      chk($sformatf("hit p%0d", p), 32'(fwd_hit[p]), 32'(s != '0));
      chk($sformatf("hit2 p%0d", p), 32'(fwd_hit2[p]), 32'(s != '0));
    end
    chk("cnt", 32'(fwd_cnt), rst_n ? 32'(m_cnt) : 32'd0);
    chk("cnt2", 32'(fwd_cnt2), rst_n ? 32'(m_cnt2) : 32'd0);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic clr);
    wb_we = we;
    wb_addr = a;
    wb_data = d;
    rd_addr = {r1, r0};
    clr_cnt = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_data_rf = {24'h654321, 24'h123456};
    set_in(1'b1, 4'd3, 24'h333333, 4'd3, 4'd9, 1'b0);

    // Reset held with a live write that would otherwise match.
    @(negedge clk);
    chk("rst data0", 32'(rd_data_out[23:0]), 32'h123456);
    chk("rst hit", 32'(fwd_hit), 32'h0);
    chk("rst src", 32'(fwd_src), 32'h0);
    chk("rst cnt", 32'(fwd_cnt), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    set_in(1'b0, 4'd0, 24'h0, 4'd0, 4'd0, 1'b0);
    next_cyc();

    // Live forward on port 0 only.
    set_in(1'b1, 4'd5, 24'hABCDEF, 4'd5, 4'd6, 1'b0);
    @(negedge clk);
    chk("live data0", 32'(rd_data_out[23:0]), 32'hABCDEF);
    chk("live src0", 32'(fwd_src[1:0]), 32'd1);
    chk("live data1", 32'(rd_data_out[47:24]), 32'h654321);
    chk("live src1", 32'(fwd_src[3:2]), 32'd0);
    next_cyc();
    set_in(1'b0, 4'd0, 24'h0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("live cnt", 32'(fwd_cnt), 32'd1);
    next_cyc();

    // Ageing through the history.
    set_in(1'b1, 4'd7, 24'h000111, 4'd7, 4'd9, 1'b0);
    next_cyc();
    set_in(1'b0, 4'd0, 24'h0, 4'd7, 4'd9, 1'b0);
    @(negedge clk);
    chk("age1 data", 32'(rd_data_out[23:0]), 32'h000111);
    chk("age1 src", 32'(fwd_src[1:0]), 32'd2);
    next_cyc();
    @(negedge clk);
    chk("age2 data", 32'(rd_data_out[23:0]), 32'h000111);
    chk("age2 src", 32'(fwd_src[1:0]), 32'd3);
    next_cyc();
    @(negedge clk);
    chk("age3 data", 32'(rd_data_out[23:0]), 32'h123456);
    chk("age3 src", 32'(fwd_src[1:0]), 32'd0);
    next_cyc();

    // Priority: live beats history; younger history beats older.
    set_in(1'b1, 4'd4, 24'd1, 4'd9, 4'd9, 1'b0);
    next_cyc();
    set_in(1'b1, 4'd4, 24'd2, 4'd9, 4'd9, 1'b0);
    next_cyc();
    set_in(1'b1, 4'd4, 24'd3, 4'd4, 4'd9, 1'b0);
    @(negedge clk);
    chk("prio live data", 32'(rd_data_out[23:0]), 32'd3);
    chk("prio live src", 32'(fwd_src[1:0]), 32'd1);
    next_cyc();
    set_in(1'b1, 4'd4, 24'd1, 4'd9, 4'd9, 1'b0);
    next_cyc();
    set_in(1'b1, 4'd4, 24'd2, 4'd9, 4'd9, 1'b0);
    next_cyc();
    set_in(1'b0, 4'd4, 24'd3, 4'd4, 4'd9, 1'b0);
    @(negedge clk);
    chk("prio hist data", 32'(rd_data_out[23:0]), 32'd2);
    chk("prio hist src", 32'(fwd_src[1:0]), 32'd2);
    next_cyc();

    // Zero register is never forwarded nor stored.
    set_in(1'b1, 4'd0, 24'hFFFFFF, 4'd0, 4'd9, 1'b0);
    @(negedge clk);
    chk("zero hit", 32'(fwd_hit), 32'd0);
    chk("zero data0", 32'(rd_data_out[23:0]), 32'h123456);
    next_cyc();
    set_in(1'b0, 4'd0, 24'h0, 4'd0, 4'd9, 1'b0);
    @(negedge clk);
    chk("zero h0 valid", 32'(dut.hist_vld[0]), 32'd0);
    next_cyc();

    // Saturation of the 2-bit counter, then clear under hits.
    set_in(1'b0, 4'd0, 24'h0, 4'd9, 4'd9, 1'b1);
    next_cyc();
    set_in(1'b1, 4'd2, 24'h222222, 4'd2, 4'd2, 1'b0);
    @(negedge clk);
    chk("sat cnt2 start", 32'(fwd_cnt2), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("sat cnt2 a", 32'(fwd_cnt2), 32'd2);
    next_cyc();
    @(negedge clk);
    chk("sat cnt2 b", 32'(fwd_cnt2), 32'd3);
    next_cyc();
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("sat cnt2 c", 32'(fwd_cnt2), 32'd3);
    chk("sat cnt16", 32'(fwd_cnt), 32'd6);
    next_cyc();
    set_in(1'b0, 4'd0, 24'h0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("clr cnt2", 32'(fwd_cnt2), 32'd0);
    chk("clr cnt16", 32'(fwd_cnt), 32'd0);
    next_cyc();

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      set_in(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
      rd_data_rf = {DW'($urandom), DW'($urandom)};
      next_cyc();
    end
    rst_n = 1'b1;
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
